// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport_if
//  Brief    : Bus bundle for the multiport register file: write-back port,
//             packed read ports, debug read port and init status.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_multiport_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                     RegWriteW;
    logic [AW-1:0]            RdW;
    logic [XLEN-1:0]          ResultW;
    logic [NUM_RD*AW-1:0]     raddr;
    logic [NUM_RD*XLEN-1:0]   rdata;
    logic [AW-1:0]            dbg_addr;
    logic [XLEN-1:0]          dbg_data;
    logic                     init_busy;

    // Pipeline side: issues writes and read addresses, consumes read data
    modport master (
        output RegWriteW, RdW, ResultW, raddr, dbg_addr,
        input  rdata, dbg_data, init_busy
    );

    // Register file side
    modport slave (
        input  RegWriteW, RdW, ResultW, raddr, dbg_addr,
        output rdata, dbg_data, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport
//  Brief    : RV32I integer register file. NUM_RD combinational read ports,
//             one rising-edge write port, a debug read port, x0 hardwired to
//             zero, optional write-to-read bypass and a post-reset clear
//             sequencer that loads INIT_VAL into x1..x(NREGS-1).
//  Revision : 1.0  initial release
// ============================================================================
module regfile_multiport #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NUM_RD   = 2,
    parameter int              BYPASS   = 1,
    parameter logic [XLEN-1:0] INIT_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    regfile_multiport_if.slave bus
);

    localparam int            AW       = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [AW-1:0]           clr_ptr;
    logic [AW-1:0]           clr_ptr_nxt;
    logic                    clr_we;
    logic                    busy;
    logic                    wr_ok;
    logic [XLEN-1:0]         mem [NREGS];
    logic [NUM_RD*XLEN-1:0]  rdata_all;
    logic [XLEN-1:0]         dbg_val;

    // State and clear pointer registers; reset always returns to RESET
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RESET;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    // Next-state logic: RESET -> CLEAR (ptr=1) -> one write per cycle -> READY
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        clr_we      = 1'b0;
        case (state)
            ST_RESET: begin
                state_nxt   = ST_CLEAR;
                clr_ptr_nxt = AW'(1);
            end
            ST_CLEAR: begin
                clr_we      = 1'b1;
                clr_ptr_nxt = clr_ptr + AW'(1);
                if (clr_ptr == LAST_IDX) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

    // Busy is a decode of the registered state, so it is glitch-free
    assign busy           = (state != ST_READY);
    assign bus.init_busy  = busy;

    // Pipeline writes only land once the file is valid, and never to x0
    assign wr_ok = !busy && bus.RegWriteW && (bus.RdW != '0);

    // Storage: sequencer writes while clearing, pipeline writes when ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_ptr] <= INIT_VAL;
            end else if (wr_ok) begin
                mem[bus.RdW] <= bus.ResultW;
            end
        end
    end

    // Read ports: zero while busy/reset or for x0, bypass a matching write
    always_comb begin
        logic [AW-1:0] ra;
        rdata_all = '0;
        ra        = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.raddr[k*AW +: AW];
            if (!(busy || rst) && (ra != '0)) begin
                if ((BYPASS != 0) && wr_ok && (bus.RdW == ra)) begin
                    rdata_all[k*XLEN +: XLEN] = bus.ResultW;
                end else begin
                    rdata_all[k*XLEN +: XLEN] = mem[ra];
                end
            end
        end
    end

    assign bus.rdata = rdata_all;

    // Debug port observes the array only, never the write bypass
    always_comb begin
        dbg_val = '0;
        if (!(busy || rst) && (bus.dbg_addr != '0)) begin
            dbg_val = mem[bus.dbg_addr];
        end
    end

    assign bus.dbg_data = dbg_val;

endmodule
`default_nettype wire
